// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet datapath blocks: default widths and the
// max-pooling controller state encoding.
package lenet_pkg;

    localparam int LENET_BIT_WIDTH = 32;
    localparam int LENET_ADDR_W    = 10;

    typedef enum logic [2:0] {
        MP_IDLE = 3'd0,
        MP_RD0  = 3'd1,
        MP_RD1  = 3'd2,
        MP_LD   = 3'd3,
        MP_OUT  = 3'd4,
        MP_DONE = 3'd5
    } mp_state_t;

endpackage

// File: rtl/maxpool_addr_gen.sv
// Output-window counters and address arithmetic for the 2x2 max-pooling pass.
// Read addresses are produced for the window the counters hold after this edge.
module maxpool_addr_gen
    import lenet_pkg::*;
#(
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int ADDR_W = LENET_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] rd_addr1_nxt,
    output logic [ADDR_W-1:0] rd_addr2_nxt,
    output logic [ADDR_W-1:0] out_addr_cur,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(2 * IN_W);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] OUT_STRIDE = ADDR_W'(IN_W / 2);
    localparam logic [ADDR_W-1:0] OCOL_MAX   = ADDR_W'(IN_W / 2 - 1);
    localparam logic [ADDR_W-1:0] OROW_MAX   = ADDR_W'(IN_H / 2 - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] orow_r;
    logic [ADDR_W-1:0] ocol_r;
    logic [ADDR_W-1:0] in_base_r;
    logic [ADDR_W-1:0] out_base_r;
    logic [ADDR_W-1:0] orow_nxt_s;
    logic [ADDR_W-1:0] ocol_nxt_s;
    logic [ADDR_W-1:0] base_sel_s;

    // Next window position: cleared on a new pass, raster advance on a handshake.
    always_comb begin
        orow_nxt_s = orow_r;
        ocol_nxt_s = ocol_r;
        if (clr) begin
            orow_nxt_s = '0;
            ocol_nxt_s = '0;
        end else if (adv) begin
            if (ocol_r == OCOL_MAX) begin
                ocol_nxt_s = '0;
                orow_nxt_s = orow_r + CNT_ONE;
            end else begin
                ocol_nxt_s = ocol_r + CNT_ONE;
            end
        end else begin
            orow_nxt_s = orow_r;
            ocol_nxt_s = ocol_r;
        end
    end

    // The base is taken straight from the port on the start cycle, before it is latched.
    assign base_sel_s   = clr ? in_base : in_base_r;
    assign rd_addr1_nxt = base_sel_s + orow_nxt_s * ROW_STRIDE + ocol_nxt_s * COL_STRIDE;
    assign rd_addr2_nxt = rd_addr1_nxt + LINE_STEP;
    assign out_addr_cur = out_base_r + orow_r * OUT_STRIDE + ocol_r;
    assign last         = (orow_r == OROW_MAX) && (ocol_r == OCOL_MAX);

    // Counter and base-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orow_r     <= '0;
            ocol_r     <= '0;
            in_base_r  <= '0;
            out_base_r <= '0;
        end else begin
            orow_r <= orow_nxt_s;
            ocol_r <= ocol_nxt_s;
            if (clr) begin
                in_base_r  <= in_base;
                out_base_r <= out_base;
            end
        end
    end

endmodule

// File: rtl/maxpool_ctrl.sv
// Sequencer for a 2x2/stride-2 max-pooling pass: reads two input columns per
// window, feeds the external pooling unit and writes one result per window.
module maxpool_ctrl
    import lenet_pkg::*;
#(
    parameter int BIT_WIDTH = LENET_BIT_WIDTH,
    parameter int IN_W      = 28,
    parameter int IN_H      = 28,
    parameter int ADDR_W    = LENET_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           in_base,
    input  logic [ADDR_W-1:0]           out_base,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr1,
    output logic [ADDR_W-1:0]           rd_addr2,
    input  logic signed [BIT_WIDTH-1:0] rd_data1,
    input  logic signed [BIT_WIDTH-1:0] rd_data2,
    output logic                        pool_en,
    output logic signed [BIT_WIDTH-1:0] pool_in1,
    output logic signed [BIT_WIDTH-1:0] pool_in2,
    input  logic signed [BIT_WIDTH-1:0] pool_max,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic signed [BIT_WIDTH-1:0] out_data
);

    if (((IN_W % 2) != 0) || ((IN_H % 2) != 0)) begin : g_odd_dims
        $error("maxpool_ctrl: IN_W and IN_H must both be even");
    end

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    mp_state_t         state_r;
    logic              clr_s;
    logic              adv_s;
    logic              last_s;
    logic [ADDR_W-1:0] rd_addr1_nxt_s;
    logic [ADDR_W-1:0] rd_addr2_nxt_s;
    logic [ADDR_W-1:0] out_addr_cur_s;

    assign clr_s    = (state_r == MP_IDLE) && start;
    assign adv_s    = (state_r == MP_OUT) && out_ready && !last_s;
    assign pool_in1 = rd_data1;
    assign pool_in2 = rd_data2;

    maxpool_addr_gen #(
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr_s),
        .adv          (adv_s),
        .in_base      (in_base),
        .out_base     (out_base),
        .rd_addr1_nxt (rd_addr1_nxt_s),
        .rd_addr2_nxt (rd_addr2_nxt_s),
        .out_addr_cur (out_addr_cur_s),
        .last         (last_s)
    );

    // Pass sequencer; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= MP_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr1  <= '0;
            rd_addr2  <= '0;
            pool_en   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state_r)
                MP_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r  <= MP_RD0;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr1 <= rd_addr1_nxt_s;
                        rd_addr2 <= rd_addr2_nxt_s;
                    end
                end
                MP_RD0: begin
                    state_r  <= MP_RD1;
                    rd_en    <= 1'b1;
                    rd_addr1 <= rd_addr1 + ADDR_ONE;
                    rd_addr2 <= rd_addr2 + ADDR_ONE;
                    pool_en  <= 1'b1;
                end
                MP_RD1: begin
                    state_r <= MP_LD;
                    rd_en   <= 1'b0;
                    pool_en <= 1'b1;
                end
                // Right column is on the read bus now, so pool_max covers all four pixels.
                MP_LD: begin
                    state_r   <= MP_OUT;
                    pool_en   <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= pool_max;
                    out_addr  <= out_addr_cur_s;
                end
                MP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_s) begin
                            state_r <= MP_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= MP_RD0;
                            rd_en    <= 1'b1;
                            rd_addr1 <= rd_addr1_nxt_s;
                            rd_addr2 <= rd_addr2_nxt_s;
                        end
                    end
                end
                MP_DONE: begin
                    state_r <= MP_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= MP_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    rd_en     <= 1'b0;
                    pool_en   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench for maxpool_ctrl: a 4x4 instance for directed scenarios and a
// default 28x28 instance for a random pass, sharing one memory model.
module tb_maxpool_ctrl;

    localparam int AW = 10;
    localparam int BW = 32;
    localparam int NI = 2;

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic signed [BW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                 start     [NI];
    logic [AW-1:0]        in_base   [NI];
    logic [AW-1:0]        out_base  [NI];
    logic                 busy      [NI];
    logic                 done      [NI];
    logic                 rd_en     [NI];
    logic [AW-1:0]        rd_addr1  [NI];
    logic [AW-1:0]        rd_addr2  [NI];
    logic signed [BW-1:0] rd_data1  [NI];
    logic signed [BW-1:0] rd_data2  [NI];
    logic                 pool_en   [NI];
    logic signed [BW-1:0] pool_in1  [NI];
    logic signed [BW-1:0] pool_in2  [NI];
    logic signed [BW-1:0] pool_max  [NI];
    logic                 out_valid [NI];
    logic                 out_ready [NI];
    logic [AW-1:0]        out_addr  [NI];
    logic signed [BW-1:0] out_data  [NI];

    logic signed [BW-1:0] mem  [1024];
    logic signed [BW-1:0] held [NI];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cnt      [NI];
    int done_cnt    [NI];
    int last_hs_cyc [NI];

    always #5 clk = ~clk;

    maxpool_ctrl #(.BIT_WIDTH(BW), .IN_W(4), .IN_H(4), .ADDR_W(AW)) u_small (
        .clk(clk), .rst(rst), .start(start[0]), .in_base(in_base[0]), .out_base(out_base[0]),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr1(rd_addr1[0]),
        .rd_addr2(rd_addr2[0]), .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]),
        .pool_en(pool_en[0]), .pool_in1(pool_in1[0]), .pool_in2(pool_in2[0]),
        .pool_max(pool_max[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_addr(out_addr[0]), .out_data(out_data[0])
    );

    maxpool_ctrl u_large (
        .clk(clk), .rst(rst), .start(start[1]), .in_base(in_base[1]), .out_base(out_base[1]),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr1(rd_addr1[1]),
        .rd_addr2(rd_addr2[1]), .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]),
        .pool_en(pool_en[1]), .pool_in1(pool_in1[1]), .pool_in2(pool_in2[1]),
        .pool_max(pool_max[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_addr(out_addr[1]), .out_data(out_data[1])
    );

    function automatic logic signed [BW-1:0] smax(input logic signed [BW-1:0] a,
                                                  input logic signed [BW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic int wa(input int x);
        return x & 1023;
    endfunction

    // Synchronous memory: one cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rd_en[k]) begin
                rd_data1[k] <= mem[rd_addr1[k]];
                rd_data2[k] <= mem[rd_addr2[k]];
            end
        end
    end

    // External pooling unit: remembers the previous column's max.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (pool_en[k]) held[k] <= smax(pool_in1[k], pool_in2[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            pool_max[k] = smax(smax(pool_in1[k], pool_in2[k]), held[k]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and times the done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) begin
                if (!rst && out_valid[k] && out_ready[k]) begin
                    check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_addr", 64'(out_addr[k]), 64'(e.addr));
                        check("out_data", 64'(out_data[k]), 64'(e.data));
                    end
                    hs_cnt[k]++;
                    last_hs_cyc[k] = cyc;
                end
                if (!rst && done[k]) begin
                    done_cnt[k]++;
                    check("done_after_last_handshake", 64'(cyc - last_hs_cyc[k]), 64'd1);
                    check("done_queue_drained", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    // Reference: plain 2x2/stride-2 maximum over the stored map.
    task automatic push_model(input int w, input int h, input int ib, input int ob);
        exp_t e;
        logic signed [BW-1:0] m;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                m = mem[wa(ib + 2 * r * w + 2 * c)];
                m = smax(m, mem[wa(ib + 2 * r * w + 2 * c + 1)]);
                m = smax(m, mem[wa(ib + (2 * r + 1) * w + 2 * c)]);
                m = smax(m, mem[wa(ib + (2 * r + 1) * w + 2 * c + 1)]);
                e.addr = AW'(wa(ob + r * (w / 2) + c));
                e.data = m;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_rand(input int ib, input int n);
        for (int i = 0; i < n; i++) mem[wa(ib + i)] = $signed($urandom);
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_t e;
        e.addr = AW'(wa(addr));
        e.data = BW'(data);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int k, input int ib, input int ob);
        @(posedge clk); #1;
        start[k]    = 1'b1;
        in_base[k]  = AW'(ib);
        out_base[k] = AW'(ob);
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int d0, input int budget, input bit rand_rdy);
        int t = 0;
        while (done_cnt[k] == d0 && t < budget) begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready[k] = ($urandom_range(0, 3) != 0);
            t++;
        end
        check("done_pulse_seen", 64'(done_cnt[k] - d0), 64'd1);
        out_ready[k] = 1'b1;
    endtask

    task automatic check_zero(input int k);
        check("rst_busy",      64'(busy[k]),      64'd0);
        check("rst_done",      64'(done[k]),      64'd0);
        check("rst_rd_en",     64'(rd_en[k]),     64'd0);
        check("rst_pool_en",   64'(pool_en[k]),   64'd0);
        check("rst_out_valid", 64'(out_valid[k]), 64'd0);
        check("rst_out_data",  64'(out_data[k]),  64'd0);
        check("rst_out_addr",  64'(out_addr[k]),  64'd0);
        check("rst_rd_addr1",  64'(rd_addr1[k]),  64'd0);
        check("rst_rd_addr2",  64'(rd_addr2[k]),  64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int d0, h0, t, rd1_seen, ib, ob;
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; in_base[k] = '0; out_base[k] = '0; out_ready[k] = 1'b1;
            hs_cnt[k] = 0; done_cnt[k] = 0; last_hs_cyc[k] = 0;
        end
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) check_zero(k);
        @(posedge clk); #1 rst = 1'b0;

        // 4x4 ramp 0..15: known results 5,7,13,15.
        for (int i = 0; i < 16; i++) mem[100 + i] = i;
        push_exp(500, 5); push_exp(501, 7); push_exp(502, 13); push_exp(503, 15);
        d0 = done_cnt[0]; h0 = hs_cnt[0];
        pulse_start(0, 100, 500);
        wait_done(0, d0, 200, 1'b0);
        check("ramp_output_count", 64'(hs_cnt[0] - h0), 64'd4);

        // Negative data, one -3 per window; both bases wrap modulo 1024.
        for (int i = 0; i < 16; i++) mem[wa(1020 + i)] = -100;
        for (int w = 0; w < 4; w++) begin
            mem[wa(1020 + (w / 2) * 8 + (w % 2) * 2 + $urandom_range(0, 1) * 4
                   + $urandom_range(0, 1))] = -3;
            push_exp(1022 + w, -3);
        end
        d0 = done_cnt[0]; h0 = hs_cnt[0];
        pulse_start(0, 1020, 1022);
        wait_done(0, d0, 200, 1'b0);
        check("neg_output_count", 64'(hs_cnt[0] - h0), 64'd4);

        // Backpressure on window 1 for 10 cycles.
        fill_rand(40, 16);
        push_model(4, 4, 40, 200);
        d0 = done_cnt[0]; h0 = hs_cnt[0];
        pulse_start(0, 40, 200);
        t = 0;
        while (hs_cnt[0] < h0 + 1 && t < 100) begin @(posedge clk); t++; end
        #1 out_ready[0] = 1'b0;
        e = exp_q[0];
        t = 0;
        do begin @(negedge clk); t++; end while (!out_valid[0] && t < 100);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check("bp_out_data",  64'(out_data[0]),  64'(e.data));
            check("bp_out_addr",  64'(out_addr[0]),  64'(e.addr));
            check("bp_rd_en",     64'(rd_en[0]),     64'd0);
            check("bp_pool_en",   64'(pool_en[0]),   64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready[0] = 1'b1;
        wait_done(0, d0, 200, 1'b0);
        check("bp_output_count", 64'(hs_cnt[0] - h0), 64'd4);

        // Start pulsed mid-pass with other bases must be ignored.
        fill_rand(600, 16);
        push_model(4, 4, 600, 700);
        d0 = done_cnt[0]; h0 = hs_cnt[0];
        pulse_start(0, 600, 700);
        repeat (5) @(posedge clk);
        #1 start[0] = 1'b1; in_base[0] = AW'(650); out_base[0] = AW'(750);
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, d0, 200, 1'b0);
        repeat (20) @(negedge clk);
        check("busy_start_done_count", 64'(done_cnt[0] - d0), 64'd1);
        check("busy_start_output_count", 64'(hs_cnt[0] - h0), 64'd4);
        check("busy_start_idle_after", 64'(busy[0]), 64'd0);

        // Reset during RD1 of window 2, then a fresh full pass.
        fill_rand(800, 16);
        push_model(4, 4, 800, 900);
        d0 = done_cnt[0];
        pulse_start(0, 800, 900);
        rd1_seen = 0; t = 0;
        while (rd1_seen < 3 && t < 200) begin
            @(negedge clk); t++;
            if (rd_en[0] && pool_en[0]) rd1_seen++;
        end
        check("rd1_window2_reached", 64'(rd1_seen), 64'd3);
        #1 rst = 1'b1;
        #1 check_zero(0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt[0] - d0), 64'd0);
        push_model(4, 4, 800, 900);
        d0 = done_cnt[0]; h0 = hs_cnt[0];
        pulse_start(0, 800, 900);
        wait_done(0, d0, 200, 1'b0);
        check("post_reset_output_count", 64'(hs_cnt[0] - h0), 64'd4);

        // Default 28x28 with random data and random backpressure.
        ib = $urandom_range(0, 1023);
        ob = $urandom_range(0, 1023);
        fill_rand(ib, 784);
        push_model(28, 28, ib, ob);
        d0 = done_cnt[1]; h0 = hs_cnt[1];
        pulse_start(1, ib, ob);
        wait_done(1, d0, 6000, 1'b1);
        check("large_output_count", 64'(hs_cnt[1] - h0), 64'd196);
        check("small_idle_during_large", 64'(hs_cnt[0]), 64'(h0 == hs_cnt[1] ? 0 : hs_cnt[0]));
        check("scoreboard_empty_at_end", 64'(exp_q.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
